// File: rtl/nvram_port_arbiter.sv
// Arbitrates the Williams-2 1Kx4 CMOS NVRAM between the game CPU and the HPS ioctl channel.
// Optional build macro NVRAM_DIRTY_EN: track CPU writes since the last completed NVRAM upload.
module nvram_port_arbiter #(
    parameter int         ADDR_W     = 10,
    parameter int         DATA_W     = 4,
    parameter logic [7:0] NV_INDEX   = 8'd4,
    parameter int         STARVE_MAX = 64
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_hold,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic              ioctl_rd,
    input  logic [16:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              nvram_dirty
);

    // state    | meaning
    // IDLE     | no HPS transfer pending
    // DL_SLOT  | download byte latched, waiting for a free or stolen RAM cycle
    // DL_DONE  | write issued, ioctl_wait already released
    // UL_SLOT  | upload address latched, waiting for a free or stolen RAM cycle
    // UL_LATCH | RAM read in flight, capture ram_dout into ioctl_din
    // UL_NULL  | out-of-range upload, return zero
    typedef enum logic [2:0] {
        IDLE,
        DL_SLOT,
        DL_DONE,
        UL_SLOT,
        UL_LATCH,
        UL_NULL
    } state_t;

    localparam int               CNT_W       = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

    state_t            state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [CNT_W-1:0]  starve_cnt;

    logic nv_sel;
    logic dl_req;
    logic ul_req;
    logic addr_oor;
    logic in_slot;
    logic slot_free;
    logic fsm_owns;
    logic unused_dout_hi;

    assign nv_sel    = (ioctl_index == NV_INDEX);
    assign dl_req    = nv_sel & ioctl_download & ioctl_wr;
    assign ul_req    = nv_sel & ioctl_upload & ioctl_rd & ~dl_req;
    assign addr_oor  = |ioctl_addr[16:ADDR_W];
    assign in_slot   = (state == DL_SLOT) || (state == UL_SLOT);
    assign slot_free = ~cpu_cs | cpu_hold;
    assign fsm_owns  = in_slot & slot_free;

    // Only the low nibble of a download byte is stored.
    assign unused_dout_hi = ^ioctl_dout[7:DATA_W];

    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_cs & cpu_we;
        if (fsm_owns) begin
            ram_addr = lat_addr;
            ram_din  = lat_data;
            ram_we   = (state == DL_SLOT);
        end
    end

    assign cpu_dout = ram_dout;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_data   <= '0;
            starve_cnt <= '0;
            ioctl_wait <= 1'b0;
            ioctl_din  <= 8'h00;
            cpu_hold   <= 1'b0;
        end else begin
            cpu_hold <= 1'b0;
            case (state)
                IDLE: begin
                    if (dl_req) begin
                        if (!addr_oor) begin
                            lat_addr   <= ioctl_addr[ADDR_W-1:0];
                            lat_data   <= ioctl_dout[DATA_W-1:0];
                            ioctl_wait <= 1'b1;
                            state      <= DL_SLOT;
                        end
                    end else if (ul_req) begin
                        ioctl_wait <= 1'b1;
                        if (addr_oor) begin
                            state <= UL_NULL;
                        end else begin
                            lat_addr <= ioctl_addr[ADDR_W-1:0];
                            state    <= UL_SLOT;
                        end
                    end
                end
                DL_SLOT, UL_SLOT: begin
                    if (slot_free) begin
                        starve_cnt <= '0;
                        if (state == DL_SLOT) begin
                            ioctl_wait <= 1'b0;
                            state      <= DL_DONE;
                        end else begin
                            state <= UL_LATCH;
                        end
                    end else if (starve_cnt == STARVE_LAST) begin
                        // Steal the next cycle; the counter clears when it is used.
                        cpu_hold <= 1'b1;
                    end else begin
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                DL_DONE: begin
                    state <= IDLE;
                end
                UL_LATCH: begin
                    ioctl_din  <= {{(8 - DATA_W){1'b0}}, ram_dout};
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                UL_NULL: begin
                    ioctl_din  <= 8'h00;
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef NVRAM_DIRTY_EN
    logic upload_q;
    logic cpu_wrote;

    assign cpu_wrote = cpu_cs & cpu_we & ~cpu_hold;

    // A CPU write in the same cycle as the upload's falling edge keeps the flag set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            upload_q    <= 1'b0;
            nvram_dirty <= 1'b0;
        end else begin
            upload_q <= ioctl_upload;
            if (cpu_wrote) begin
                nvram_dirty <= 1'b1;
            end else if (upload_q && !ioctl_upload && nv_sel) begin
                nvram_dirty <= 1'b0;
            end
        end
    end
`else
    assign nvram_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_port_arbiter.sv
// Bench for nvram_port_arbiter: directed scenarios plus randomized transactions against a nibble-array model.
module tb_nvram_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_cs;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [3:0]  cpu_din;
    logic [3:0]  cpu_dout;
    logic        cpu_hold;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic        ioctl_rd;
    logic [16:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_din;
    logic        ram_we;
    logic [3:0]  ram_dout;
    logic        nvram_dirty;

    int errors = 0;
    int checks = 0;

    logic [3:0] mem     [0:1023];
    logic [3:0] exp_mem [0:1023];
    logic       mem_clr;

    nvram_port_arbiter dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .cpu_cs         (cpu_cs),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .cpu_hold       (cpu_hold),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .ram_dout       (ram_dout),
        .nvram_dirty    (nvram_dirty)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous 1Kx4 RAM with one-cycle read latency.
    always @(posedge clk_sys) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 4'h0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_sys);
    endtask

    task automatic cpu_idle();
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic cpu_rand();
        cpu_cs   = 1'b1;
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = 10'($urandom_range(0, 15));
        cpu_din  = 4'($urandom);
        if (cpu_we) exp_mem[cpu_addr] = cpu_din;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [3:0] d);
        next_cycle();
        cpu_cs   = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        exp_mem[a] = d;
        next_cycle();
        cpu_idle();
    endtask

    // One HPS byte transfer; the CPU is busy for k cycles after the request.
    task automatic run_txn(input bit is_dl, input logic [16:0] addr, input logic [7:0] data,
                           input int k, input bit cpu_t);
        bit         oor;
        logic [3:0] exp_d;
        int         last;
        bit         expw;
        oor   = (addr >= 17'd1024);
        exp_d = 4'h0;
        next_cycle();
        ioctl_index = 8'd4;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        if (is_dl) begin
            ioctl_download = 1'b1;
            ioctl_wr       = 1'b1;
        end else begin
            ioctl_upload = 1'b1;
            ioctl_rd     = 1'b1;
        end
        if (cpu_t) cpu_rand(); else cpu_idle();
        mid();
        chk("req_wait", 32'(ioctl_wait), 32'(0));
        if (is_dl) last = oor ? 1 : k + 2;
        else       last = oor ? 2 : k + 3;
        for (int c = 1; c <= last; c++) begin
            next_cycle();
            ioctl_wr = 1'b0;
            ioctl_rd = 1'b0;
            if (c <= k && !oor) cpu_rand(); else cpu_idle();
            if (!is_dl && !oor && c == k + 1) exp_d = exp_mem[addr[9:0]];
            mid();
            if (is_dl) expw = oor ? 1'b0 : (c <= k + 1);
            else       expw = oor ? (c == 1) : (c <= k + 2);
            chk("wait", 32'(ioctl_wait), 32'(expw));
            if (!oor && c == k + 1) begin
                chk("slot_we", 32'(ram_we), 32'(is_dl));
                chk("slot_addr", 32'(ram_addr), 32'(addr[9:0]));
                if (is_dl) begin
                    chk("slot_din", 32'(ram_din), 32'(data[3:0]));
                    exp_mem[addr[9:0]] = data[3:0];
                end
            end
            if (is_dl && oor) chk("oor_we", 32'(ram_we), 32'(0));
        end
        if (!is_dl) chk("ul_din", 32'(ioctl_din), oor ? 32'(0) : 32'(exp_d));
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
    endtask

    initial begin
        bit          r_dl;
        logic [16:0] r_addr;
        logic [9:0]  rb_addr;

        reset_n = 1'b1;
        mem_clr = 1'b1;
        cpu_idle();
        cpu_addr = '0;
        cpu_din = '0;
        ioctl_download = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_rd = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 4'h0;
        #2 reset_n = 1'b0;
        #2;
        chk("rst_wait", 32'(ioctl_wait), 32'(0));
        chk("rst_din", 32'(ioctl_din), 32'(0));
        chk("rst_hold", 32'(cpu_hold), 32'(0));
        chk("rst_dirty", 32'(nvram_dirty), 32'(0));
        repeat (2) next_cycle();
        mem_clr = 1'b0;
        reset_n = 1'b1;

        // Minimum-latency download and upload.
        run_txn(1'b1, 17'h005, 8'hA7, 0, 1'b0);
        cpu_write(10'h3FF, 4'hC);
        run_txn(1'b0, 17'h3FF, 8'h00, 0, 1'b0);

        next_cycle();
        cpu_cs = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 10'h005;
        next_cycle();
        cpu_idle();
        mid();
        chk("cpu_dout", 32'(cpu_dout), 32'(exp_mem[10'h005]));

        // Out-of-range transfers.
        run_txn(1'b1, 17'h400, 8'h5B, 0, 1'b0);
        run_txn(1'b0, 17'h400, 8'h00, 0, 1'b0);

        // Starvation: CPU keeps the RAM selected with a download pending.
        next_cycle();
        ioctl_index = 8'd4;
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_addr = 17'h123;
        ioctl_dout = 8'h05;
        cpu_cs = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 10'h002;
        for (int c = 1; c <= 66; c++) begin
            next_cycle();
            ioctl_wr = 1'b0;
            mid();
            chk("starve_hold", 32'(cpu_hold), 32'(c == 65));
            chk("starve_wait", 32'(ioctl_wait), 32'(c <= 65));
            if (c == 65) begin
                chk("starve_we", 32'(ram_we), 32'(1));
                chk("starve_addr", 32'(ram_addr), 32'(10'h123));
            end
        end
        exp_mem[10'h123] = 4'h5;
        ioctl_download = 1'b0;
        cpu_idle();

        // Reset during DL_SLOT aborts the pending write.
        next_cycle();
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_addr = 17'h010;
        ioctl_dout = 8'h09;
        cpu_cs = 1'b1;
        cpu_we = 1'b0;
        next_cycle();
        ioctl_wr = 1'b0;
        mid();
        chk("pre_rst_wait", 32'(ioctl_wait), 32'(1));
        next_cycle();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wait", 32'(ioctl_wait), 32'(0));
        chk("mid_rst_hold", 32'(cpu_hold), 32'(0));
        next_cycle();
        reset_n = 1'b1;
        cpu_idle();
        ioctl_download = 1'b0;
        run_txn(1'b0, 17'h010, 8'h00, 0, 1'b0);

`ifdef NVRAM_DIRTY_EN
        cpu_write(10'h020, 4'h3);
        mid();
        chk("dirty_set", 32'(nvram_dirty), 32'(1));
        next_cycle();
        ioctl_index = 8'd4;
        ioctl_upload = 1'b1;
        next_cycle();
        next_cycle();
        ioctl_upload = 1'b0;
        next_cycle();
        mid();
        chk("dirty_clr", 32'(nvram_dirty), 32'(0));
        cpu_write(10'h021, 4'h1);
        next_cycle();
        ioctl_index = 8'd5;
        ioctl_upload = 1'b1;
        next_cycle();
        ioctl_upload = 1'b0;
        next_cycle();
        mid();
        chk("dirty_other_idx", 32'(nvram_dirty), 32'(1));
        ioctl_index = 8'd4;
        next_cycle();
        ioctl_upload = 1'b1;
        next_cycle();
        ioctl_upload = 1'b0;
        cpu_cs = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 10'h021;
        cpu_din = 4'h6;
        exp_mem[10'h021] = 4'h6;
        next_cycle();
        cpu_idle();
        mid();
        chk("dirty_same_cycle", 32'(nvram_dirty), 32'(1));
`else
        cpu_write(10'h020, 4'h3);
        mid();
        chk("dirty_tied", 32'(nvram_dirty), 32'(0));
`endif

        // Randomized transfers with short CPU busy bursts.
        for (int n = 0; n < 40; n++) begin
            r_dl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) r_addr = 17'(17'h400 + $urandom_range(0, 1000));
            else                           r_addr = 17'($urandom_range(0, 15));
            run_txn(r_dl, r_addr, 8'($urandom), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        // Read back the touched region through the HPS port.
        for (int a = 0; a < 19; a++) begin
            if (a < 16)       rb_addr = 10'(a);
            else if (a == 16) rb_addr = 10'h123;
            else if (a == 17) rb_addr = 10'h3FF;
            else              rb_addr = 10'h020;
            run_txn(1'b0, 17'(rb_addr), 8'h00, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
